// File: rtl/adder_pipe_acc.sv
// WIDTH-bit add/subtract/accumulate unit with valid/ready handshakes and a DEPTH-entry result FIFO.
// Define ADDER_SATURATE_EN to clamp results instead of wrapping.
module adder_pipe_acc #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [WIDTH-1:0]           A,
  input  logic [WIDTH-1:0]           B,
  input  logic [1:0]                 mode,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [WIDTH-1:0]           sum,
  output logic                       carry,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = $clog2(DEPTH);

  localparam logic [1:0] ModeAdd = 2'b00;
  localparam logic [1:0] ModeSub = 2'b01;
  localparam logic [1:0] ModeAcc = 2'b10;
  localparam logic [1:0] ModeClr = 2'b11;

  logic [WIDTH-1:0] acc_q;
  logic [CW-1:0]    count_q;
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [WIDTH-1:0] mem_sum [DEPTH];
  logic             mem_carry [DEPTH];

  logic             push, pop;
  logic [WIDTH:0]   add_full, sub_full, acc_full;
  logic [WIDTH-1:0] res_sum;
  logic             res_carry;

  // Full FIFO refuses pushes even when a pop happens in the same cycle.
  assign in_ready  = (count_q < CW'(DEPTH));
  assign out_valid = (count_q != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign count     = count_q;

  assign sum   = out_valid ? mem_sum[rd_ptr_q]   : '0;
  assign carry = out_valid ? mem_carry[rd_ptr_q] : 1'b0;

  assign add_full = {1'b0, A} + {1'b0, B};
  assign sub_full = {1'b0, A} - {1'b0, B};
  assign acc_full = {1'b0, acc_q} + {1'b0, A};

  always_comb begin
    res_sum   = '0;
    res_carry = 1'b0;
    unique case (mode)
      ModeAdd: begin
        res_sum   = add_full[WIDTH-1:0];
        res_carry = add_full[WIDTH];
`ifdef ADDER_SATURATE_EN
        if (res_carry) res_sum = '1;
`endif
      end
      ModeSub: begin
        // Top bit of the widened difference is the unsigned borrow.
        res_sum   = sub_full[WIDTH-1:0];
        res_carry = sub_full[WIDTH];
`ifdef ADDER_SATURATE_EN
        if (res_carry) res_sum = '0;
`endif
      end
      ModeAcc: begin
        res_sum   = acc_full[WIDTH-1:0];
        res_carry = acc_full[WIDTH];
`ifdef ADDER_SATURATE_EN
        if (res_carry) res_sum = '1;
`endif
      end
      ModeClr: begin
        res_sum   = '0;
        res_carry = 1'b0;
      end
      default: begin
        res_sum   = '0;
        res_carry = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      acc_q    <= '0;
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push && (mode == ModeAcc || mode == ModeClr)) acc_q <= res_sum;
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      unique case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset: entries are only visible while count is non-zero.
  always_ff @(posedge clock) begin
    if (push) begin
      mem_sum[wr_ptr_q]   <= res_sum;
      mem_carry[wr_ptr_q] <= res_carry;
    end
  end

endmodule

// File: tb/tb_adder_pipe_acc.sv
// Directed self-checking bench for adder_pipe_acc (WIDTH=8, DEPTH=4).
// Expected values follow ADDER_SATURATE_EN when it is defined.
module tb_adder_pipe_acc;

  logic       clock, reset;
  logic [7:0] A, B;
  logic [1:0] mode;
  logic       in_valid, in_ready, out_valid, out_ready, carry;
  logic [7:0] sum;
  logic [2:0] count;

  int checks = 0;
  int errors = 0;

  adder_pipe_acc #(.WIDTH(8), .DEPTH(4)) dut (
    .clock(clock), .reset(reset), .A(A), .B(B), .mode(mode),
    .in_valid(in_valid), .in_ready(in_ready), .sum(sum), .carry(carry),
    .out_valid(out_valid), .out_ready(out_ready), .count(count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

`ifdef ADDER_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  // Stimulus only: one accepted operation, result visible 1 time unit after the edge.
  task automatic push(input logic [1:0] m, input logic [7:0] a, input logic [7:0] b);
    @(negedge clock);
    mode = m; A = a; B = b; in_valid = 1'b1;
    @(posedge clock); #1;
    in_valid = 1'b0;
  endtask

  task automatic pop();
    @(negedge clock);
    out_ready = 1'b1;
    @(posedge clock); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b want 0", out_valid); end
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL rst_count got %0d want 0", count); end
    checks++; if (sum !== 8'h00) begin errors++; $display("FAIL rst_sum got %h want 00", sum); end
    checks++; if (carry !== 1'b0) begin errors++; $display("FAIL rst_carry got %b want 0", carry); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got %b want 1", in_ready); end
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_add();
    push(2'b00, 8'h7F, 8'h01);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL add1_valid got %b want 1", out_valid); end
    checks++; if (sum !== 8'h80) begin errors++; $display("FAIL add1_sum got %h want 80", sum); end
    checks++; if (carry !== 1'b0) begin errors++; $display("FAIL add1_carry got %b want 0", carry); end
    checks++; if (count !== 3'd1) begin errors++; $display("FAIL add1_count got %0d want 1", count); end
    pop();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL add_empty_valid got %b want 0", out_valid); end
    checks++; if (sum !== 8'h00) begin errors++; $display("FAIL add_empty_sum got %h want 00", sum); end
    push(2'b00, 8'hFF, 8'h02);
    checks++; if (sum !== (SAT ? 8'hFF : 8'h01)) begin errors++; $display("FAIL add2_sum got %h want %h", sum, SAT ? 8'hFF : 8'h01); end
    checks++; if (carry !== 1'b1) begin errors++; $display("FAIL add2_carry got %b want 1", carry); end
    pop();
  endtask

  task automatic test_sub();
    push(2'b01, 8'h07, 8'h05);
    checks++; if (sum !== 8'h02) begin errors++; $display("FAIL sub1_sum got %h want 02", sum); end
    checks++; if (carry !== 1'b0) begin errors++; $display("FAIL sub1_carry got %b want 0", carry); end
    pop();
    push(2'b01, 8'h05, 8'h07);
    checks++; if (sum !== (SAT ? 8'h00 : 8'hFE)) begin errors++; $display("FAIL sub2_sum got %h want %h", sum, SAT ? 8'h00 : 8'hFE); end
    checks++; if (carry !== 1'b1) begin errors++; $display("FAIL sub2_carry got %b want 1", carry); end
    pop();
  endtask

  task automatic test_acc();
    logic [7:0] exp_s [5];
    logic       exp_c [5];
    exp_s = SAT ? '{8'h40, 8'h80, 8'hC0, 8'hFF, 8'hFF} : '{8'h40, 8'h80, 8'hC0, 8'h00, 8'h40};
    exp_c = SAT ? '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1} : '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    push(2'b11, 8'h55, 8'h66);
    checks++; if (sum !== 8'h00 || carry !== 1'b0) begin errors++; $display("FAIL clr1 got %h/%b want 00/0", sum, carry); end
    pop();
    for (int i = 0; i < 5; i++) begin
      push(2'b10, 8'h40, 8'hAA);
      checks++;
      if (sum !== exp_s[i] || carry !== exp_c[i]) begin
        errors++; $display("FAIL acc%0d got %h/%b want %h/%b", i, sum, carry, exp_s[i], exp_c[i]);
      end
      pop();
    end
    push(2'b11, 8'h00, 8'h00);
    checks++; if (sum !== 8'h00 || carry !== 1'b0) begin errors++; $display("FAIL clr2 got %h/%b want 00/0", sum, carry); end
    pop();
  endtask

  task automatic test_backpressure();
    for (int i = 1; i <= 4; i++) push(2'b00, 8'(i), 8'(i));
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL bp_full_count got %0d want 4", count); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_full_ready got %b want 0", in_ready); end
    // Fifth operation is offered and must be held while full.
    @(negedge clock);
    mode = 2'b00; A = 8'h05; B = 8'h05; in_valid = 1'b1;
    @(posedge clock); #1;
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL bp_held_count got %0d want 4", count); end
    @(negedge clock);
    out_ready = 1'b1;
    #1;
    checks++; if (sum !== 8'h02) begin errors++; $display("FAIL drain0 got %h want 02", sum); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_pop_ready got %b want 0", in_ready); end
    @(posedge clock); #1;
    checks++; if (count !== 3'd3) begin errors++; $display("FAIL full_pop_count got %0d want 3", count); end
    checks++; if (sum !== 8'h04) begin errors++; $display("FAIL drain1 got %h want 04", sum); end
    @(posedge clock); #1;
    in_valid = 1'b0;
    checks++; if (count !== 3'd3) begin errors++; $display("FAIL push_pop_count got %0d want 3", count); end
    checks++; if (sum !== 8'h06) begin errors++; $display("FAIL drain2 got %h want 06", sum); end
    @(posedge clock); #1;
    checks++; if (sum !== 8'h08 || count !== 3'd2) begin errors++; $display("FAIL drain3 got %h/%0d want 08/2", sum, count); end
    @(posedge clock); #1;
    checks++; if (sum !== 8'h0A || count !== 3'd1) begin errors++; $display("FAIL drain4 got %h/%0d want 0A/1", sum, count); end
    @(posedge clock); #1;
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0 || count !== 3'd0) begin errors++; $display("FAIL drain_empty got %b/%0d want 0/0", out_valid, count); end
  endtask

  task automatic test_reset_mid();
    push(2'b11, 8'h00, 8'h00);
    push(2'b10, 8'h10, 8'h00);
    push(2'b10, 8'h20, 8'h00);
    checks++; if (count !== 3'd3 || sum !== 8'h00) begin errors++; $display("FAIL pre_rst got %0d/%h want 3/00", count, sum); end
    @(negedge clock); #2;
    reset = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_valid got %b want 0", out_valid); end
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL mid_rst_count got %0d want 0", count); end
    checks++; if (sum !== 8'h00) begin errors++; $display("FAIL mid_rst_sum got %h want 00", sum); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_rst_ready got %b want 1", in_ready); end
    @(negedge clock);
    reset = 1'b0;
    push(2'b10, 8'h01, 8'h00);
    checks++; if (sum !== 8'h01 || carry !== 1'b0) begin errors++; $display("FAIL post_rst_acc got %h/%b want 01/0", sum, carry); end
    pop();
  endtask

  initial begin
    reset = 1'b1; A = '0; B = '0; mode = '0; in_valid = 1'b0; out_ready = 1'b0;
    test_reset();
    test_add();
    test_sub();
    test_acc();
    test_backpressure();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
